// File: rtl/hms_pkg.sv
// Shared time-of-day types, limits and BCD helpers for the hms timekeeper
// and its display-side consumers.
package hms_pkg;

  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
  } hms_t;

  localparam logic [7:0] MAX_HH = 8'h23;
  localparam logic [7:0] MAX_MS = 8'h59;

  // Both nibbles must be decimal; then a plain compare against the BCD limit is exact.
  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max_v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max_v);
  endfunction

  function automatic logic hms_valid(input hms_t t);
    return bcd_ok(t.hh, MAX_HH) && bcd_ok(t.mm, MAX_MS) && bcd_ok(t.ss, MAX_MS);
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      return {v[7:4] + 4'd1, 4'h0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/hms_12h_conv.sv
// Combinational 24-hour to 12-hour hour converter (BCD in, BCD out) with pm flag.
module hms_12h_conv
  import hms_pkg::*;
(
  input  logic [7:0] hh24_i,
  output logic [7:0] hh12_o,
  output logic       pm_o
);

  always_comb begin
    pm_o   = (hh24_i >= 8'h12);
    hh12_o = hh24_i;
    if (hh24_i == 8'h00) begin
      hh12_o = 8'h12;
    end else if ((hh24_i >= 8'h22) || ((hh24_i >= 8'h13) && (hh24_i <= 8'h19))) begin
      // No borrow across the tens digit for these hours, so binary subtract is valid BCD.
      hh12_o = hh24_i - 8'h12;
    end else if (hh24_i >= 8'h20) begin
      hh12_o = hh24_i - 8'h18;
    end
  end

endmodule

// File: rtl/hms_timekeeper.sv
// Time-of-day counter in packed BCD with prescaler, run/stop, validated load,
// 12/24-hour display, one-shot alarm and seconds/day-wrap strobes.
module hms_timekeeper
  import hms_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter bit ALARM_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        mode_12h,
  input  logic        load,
  input  logic [23:0] time_in,
  input  logic        alarm_set,
  input  logic [23:0] alarm_in,
  input  logic        alarm_clr,
  output logic [23:0] time_out,
  output logic        pm,
  output logic        sec_tick,
  output logic        day_wrap,
  output logic        alarm,
  output logic        load_err
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  hms_t          time_q, time_d, time_inc;
  logic [PW-1:0] ps_q, ps_d;
  logic          sec_tick_q, day_wrap_q, load_err_q;
  logic          tick, adv, wrap, load_ok, set_ok;
  logic [7:0]    hh12;

  always_comb begin
    tick    = run && (ps_q == PS_LAST);
    load_ok = load && hms_valid(hms_t'(time_in));
    set_ok  = alarm_set && hms_valid(hms_t'(alarm_in));
    adv     = tick && !load_ok;

    time_inc = time_q;
    wrap     = 1'b0;
    if (time_q.ss == MAX_MS) begin
      time_inc.ss = 8'h00;
      if (time_q.mm == MAX_MS) begin
        time_inc.mm = 8'h00;
        if (time_q.hh == MAX_HH) begin
          time_inc.hh = 8'h00;
          wrap        = 1'b1;
        end else begin
          time_inc.hh = bcd_inc(time_q.hh);
        end
      end else begin
        time_inc.mm = bcd_inc(time_q.mm);
      end
    end else begin
      time_inc.ss = bcd_inc(time_q.ss);
    end

    time_d = time_q;
    if (load_ok) begin
      time_d = hms_t'(time_in);
    end else if (adv) begin
      time_d = time_inc;
    end

    // A valid load restarts the second; a stopped clock holds its partial second.
    ps_d = ps_q;
    if (load_ok || tick) begin
      ps_d = '0;
    end else if (run) begin
      ps_d = ps_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      time_q     <= '0;
      ps_q       <= '0;
      sec_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      time_q     <= time_d;
      ps_q       <= ps_d;
      sec_tick_q <= adv;
      day_wrap_q <= adv && wrap;
      load_err_q <= (load && !load_ok) || (alarm_set && !set_ok);
    end
  end

  generate
    if (ALARM_EN) begin : g_alarm
      hms_t alarm_time_q;
      logic armed_q, alarm_q, match;

      // Only a real one-second advance can fire the alarm; loads never do.
      assign match = armed_q && adv && (time_inc == alarm_time_q);

      always_ff @(posedge clk) begin
        if (reset) begin
          alarm_time_q <= '0;
          armed_q      <= 1'b0;
          alarm_q      <= 1'b0;
        end else begin
          if (set_ok) begin
            alarm_time_q <= hms_t'(alarm_in);
            armed_q      <= 1'b1;
          end else if (alarm_clr) begin
            armed_q <= 1'b0;
          end
          if (alarm_clr) begin
            alarm_q <= 1'b0;
          end else if (match) begin
            alarm_q <= 1'b1;
          end
        end
      end

      assign alarm = alarm_q;
    end else begin : g_no_alarm
      assign alarm = 1'b0;
    end
  endgenerate

  hms_12h_conv u_conv (
    .hh24_i (time_q.hh),
    .hh12_o (hh12),
    .pm_o   (pm)
  );

  assign time_out = mode_12h ? {hh12, time_q.mm, time_q.ss} : time_q;
  assign sec_tick = sec_tick_q;
  assign day_wrap = day_wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_hms_timekeeper.sv
// Scoreboard bench for hms_timekeeper with TICK_DIV=4: stimulus queues expected
// tick/load_err events, a negedge monitor pops and compares them.
module tb_hms_timekeeper;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        reset, run, mode_12h, load, alarm_set, alarm_clr;
  logic [23:0] time_in, alarm_in;
  logic [23:0] time_out;
  logic        pm, sec_tick, day_wrap, alarm, load_err;

  typedef struct packed {
    logic [23:0] t;
    logic        dw;
    logic        al;
  } exp_t;

  exp_t tick_q[$];
  bit   err_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  hms_timekeeper #(.TICK_DIV(TD), .ALARM_EN(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .mode_12h  (mode_12h),
    .load      (load),
    .time_in   (time_in),
    .alarm_set (alarm_set),
    .alarm_in  (alarm_in),
    .alarm_clr (alarm_clr),
    .time_out  (time_out),
    .pm        (pm),
    .sec_tick  (sec_tick),
    .day_wrap  (day_wrap),
    .alarm     (alarm),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
      $display("ok   %s: got %h", name, act);
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_time(input logic [23:0] v);
    time_in = v;
    load    = 1'b1;
    cyc(1);
    load    = 1'b0;
  endtask

  task automatic push_tick(input logic [23:0] t, input logic dw, input logic al);
    exp_t e;
    e.t  = t;
    e.dw = dw;
    e.al = al;
    tick_q.push_back(e);
  endtask

  // Monitor: every strobe from the DUT must match the head of its queue.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (sec_tick === 1'b1) begin
        if (tick_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected sec_tick: time_out %h, none required", time_out);
        end else begin
          exp_t e;
          e = tick_q.pop_front();
          chk("tick time_out", {8'h0, time_out}, {8'h0, e.t});
          chk("tick day_wrap", {31'h0, day_wrap}, {31'h0, e.dw});
          chk("tick alarm", {31'h0, alarm}, {31'h0, e.al});
        end
      end else if (day_wrap !== 1'b0) begin
        total_cnt++;
        $display("FAIL day_wrap without sec_tick: got %b required 0", day_wrap);
      end
      if (load_err === 1'b1) begin
        if (err_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected load_err: got 1 required 0");
        end else begin
          chk("load_err pulse", {31'h0, load_err}, {31'h0, err_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct packed {
    logic [23:0] ld;
    logic [23:0] disp;
    logic        pm_e;
  } conv_t;

  conv_t conv_tab[6];

  initial begin
    conv_tab[0] = '{24'h001500, 24'h121500, 1'b0};
    conv_tab[1] = '{24'h120000, 24'h120000, 1'b1};
    conv_tab[2] = '{24'h130509, 24'h010509, 1'b1};
    conv_tab[3] = '{24'h230000, 24'h110000, 1'b1};
    conv_tab[4] = '{24'h200000, 24'h080000, 1'b1};
    conv_tab[5] = '{24'h110000, 24'h110000, 1'b0};

    reset = 1'b1; run = 1'b0; mode_12h = 1'b0; load = 1'b0; alarm_set = 1'b0;
    alarm_clr = 1'b0; time_in = '0; alarm_in = '0;
    cyc(3);
    chk("reset time_out 24h", {8'h0, time_out}, 32'h000000);
    chk("reset flags", {28'h0, sec_tick, day_wrap, alarm, load_err}, 32'h0);
    mode_12h = 1'b1;
    #1;
    chk("reset time_out 12h", {8'h0, time_out}, 32'h120000);
    chk("reset pm", {31'h0, pm}, 32'h0);
    mode_12h = 1'b0;
    reset = 1'b0;
    cyc(1);

    // Free run: 12 cycles give three seconds.
    push_tick(24'h000001, 1'b0, 1'b0);
    push_tick(24'h000002, 1'b0, 1'b0);
    push_tick(24'h000003, 1'b0, 1'b0);
    run = 1'b1;
    cyc(12);
    run = 1'b0;
    cyc(1);
    chk("run12 time_out", {8'h0, time_out}, 32'h000003);
    chk("run12 pending ticks", tick_q.size(), 32'h0);

    // Day wrap.
    load_time(24'h235958);
    push_tick(24'h235959, 1'b0, 1'b0);
    push_tick(24'h000000, 1'b1, 1'b0);
    run = 1'b1;
    cyc(8);
    run = 1'b0;
    cyc(1);
    chk("wrap pending ticks", tick_q.size(), 32'h0);

    // Invalid loads leave time untouched.
    err_q.push_back(1'b1);
    load_time(24'h245900);
    cyc(1);
    err_q.push_back(1'b1);
    load_time(24'h125A00);
    cyc(2);
    chk("bad load time_out", {8'h0, time_out}, 32'h000000);
    chk("bad load pending errs", err_q.size(), 32'h0);

    // 12-hour display sweep.
    mode_12h = 1'b1;
    for (int i = 0; i < 6; i++) begin
      load_time(conv_tab[i].ld);
      chk($sformatf("12h time_out %h", conv_tab[i].ld), {8'h0, time_out}, {8'h0, conv_tab[i].disp});
      chk($sformatf("12h pm %h", conv_tab[i].ld), {31'h0, pm}, {31'h0, conv_tab[i].pm_e});
    end
    mode_12h = 1'b0;
    #1;
    chk("24h after sweep", {8'h0, time_out}, 32'h110000);

    // Alarm at 00:00:02, sticky until cleared.
    load_time(24'h000000);
    alarm_in  = 24'h000002;
    alarm_set = 1'b1;
    cyc(1);
    alarm_set = 1'b0;
    for (int s = 1; s <= 5; s++) begin
      push_tick(24'(s), 1'b0, (s >= 2) ? 1'b1 : 1'b0);
    end
    run = 1'b1;
    cyc(20);
    run = 1'b0;
    cyc(1);
    chk("alarm sticky", {31'h0, alarm}, 32'h1);
    chk("alarm pending ticks", tick_q.size(), 32'h0);
    alarm_clr = 1'b1;
    cyc(1);
    alarm_clr = 1'b0;
    chk("alarm after clr", {31'h0, alarm}, 32'h0);
    alarm_set = 1'b1;
    cyc(1);
    alarm_set = 1'b0;
    load_time(24'h000002);
    chk("alarm after load on match", {31'h0, alarm}, 32'h0);
    push_tick(24'h000003, 1'b0, 1'b0);
    run = 1'b1;
    cyc(4);
    run = 1'b0;
    cyc(1);

    // Load on the prescaler terminal cycle suppresses that tick.
    load_time(24'h000000);
    run = 1'b1;
    cyc(3);
    load_time(24'h000100);
    cyc(3);
    chk("no tick 3 after load", {8'h0, time_out}, 32'h000100);
    push_tick(24'h000101, 1'b0, 1'b0);
    cyc(1);
    run = 1'b0;
    cyc(1);
    chk("terminal load pending ticks", tick_q.size(), 32'h0);
    chk("final pending errs", err_q.size(), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hms_timekeeper.md
# hms_timekeeper

Parametrised real-time-of-day counter holding hours/minutes/seconds in packed BCD, advancing once per programmable number of clock cycles. It adds run/stop, synchronous time load with validity checking, 12/24-hour display mode, a one-shot alarm, and seconds/day-wrap strobes. It sits between the board clock domain and the display and alarm logic, and replaces the fixed 24-hour clock.

## Interface
Parameters:
- TICK_DIV, 100_000_000: clock cycles per second; legal range ≥ 2; benches use 4.
- ALARM_EN, 1: when 0, alarm logic is removed and `alarm` is tied to 0.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  reset, synchronous, active-high.
- run  in  1  1 = prescaler counts and time advances; 0 = freeze, with prescaler held.
- mode_12h  in  1  output format select; does not affect internal state.
- load  in  1  one-cycle request to load `time_in`.
- time_in  in  24  BCD {HH,MM,SS}, always 24-hour format.
- alarm_set  in  1  one-cycle request to load `alarm_in` and arm the alarm.
- alarm_in  in  24  BCD {HH,MM,SS}, 24-hour format.
- alarm_clr  in  1  clears `alarm` and disarms.
- time_out  out  24  current time in BCD; HH is 01..12 when `mode_12h`=1.
- pm  out  1  1 when internal hour ≥ 12; valid in both modes.
- sec_tick  out  1  one-cycle pulse when the time advances.
- day_wrap  out  1  one-cycle pulse on 23:59:59 → 00:00:00.
- alarm  out  1  sticky match flag.
- load_err  out  1  one-cycle pulse when `load` or `alarm_set` carries invalid BCD.

## Operation
- State: six BCD digit registers, a prescaler of width $clog2(TICK_DIV), the alarm time register, and `armed`.
- Prescaler counts 0..TICK_DIV-1 while `run`=1. On the edge where count = TICK_DIV-1, count returns to 0 and the time advances by 1 s.
- Carry chain:
  - SS 00..59, then MM 00..59, then HH 00..23.
  - Digit arithmetic is BCD only; binary values 0xA–0xF never appear in any digit.
- Validity rules: HH ≤ 0x23, MM ≤ 0x59, SS ≤ 0x59, each nibble ≤ 9.
  - Invalid `load`: state unchanged, `load_err` pulses.
  - Invalid `alarm_set`: alarm register unchanged, `load_err` pulses.
- Valid `load`: all six digits are replaced and the prescaler is cleared to 0.
- Load vs tick: `load` has priority over a tick in the same cycle. That tick is discarded, and no `sec_tick` or `day_wrap` is produced.
- Alarm set: valid `alarm_set` stores `alarm_in` and sets `armed`=1.
- Alarm match:
  - `alarm` sets when `armed` and a tick advances time to equal the alarm register.
  - A `load` that lands on the alarm time does not set `alarm`.
  - `alarm` stays high until `alarm_clr`; `alarm_clr` clears both `alarm` and `armed`.
  - `alarm_clr` and a match in the same cycle: `alarm_clr` wins. `alarm_set` and `alarm_clr` in the same cycle: `alarm_set` wins.
- 12-hour decode (combinational from state):
  - HH 00 → 12, `pm`=0.
  - 01–11 → unchanged, `pm`=0.
  - 12 → 12, `pm`=1.
  - 13–23 → HH−12, in BCD, `pm`=1.

## Timing
- Reset values: time 00:00:00, prescaler 0, alarm register 00:00:00, `armed`=0. Outputs: `alarm`=0, `sec_tick`=0, `day_wrap`=0, `load_err`=0. `time_out` reads 00:00:00 in 24-hour mode, or 12:00:00 with `pm`=0 in 12-hour mode.
- `reset` overrides all other inputs in the same cycle. Reset asserted mid-count discards the partial second.
- Tick timing: the first tick after reset or load occurs TICK_DIV cycles later with `run` held at 1.
- Registered updates: the new time, `sec_tick`, `day_wrap` and `alarm` are all registered on the same edge and become visible together.
- Load timing: `load` or `alarm_set` takes effect at the next edge. `load_err` is registered and pulses the cycle after the bad request.
- Combinational outputs: `time_out` and `pm` follow `mode_12h` combinationally, with zero cycles of latency.
- `run`=0 with `load`=1: the load still executes.

## Structure
- Package `hms_pkg`: packed struct `hms_t` (hh, mm, ss, each 8-bit BCD), constants MAX_HH=8'h23 and MAX_MS=8'h59, and the function `hms_valid(hms_t)`.
- Sub-module `hms_12h_conv`: combinational 24-hour to 12-hour hour/pm converter, reused by the display block.
- Everything else, including prescaler, digit counters and alarm, stays in `hms_timekeeper`.

## Test plan
All scenarios use TICK_DIV=4.
- Reset, then `run`=1 for 12 cycles → exactly 3 `sec_tick` pulses; `time_out`=24'h000003.
- `load` 24'h235958, run 8 cycles → 23:59:59, then 00:00:00 with a single `day_wrap` pulse on the wrap edge.
- `load` 24'h245900, then `load` 24'h125A00 → two `load_err` pulses; time unchanged at 00:00:00.
- `mode_12h`=1 sweep via loads:
  - 00:15:00 → 12:15:00, `pm`=0.
  - 12:00:00 → 12:00:00, `pm`=1.
  - 13:05:09 → 01:05:09, `pm`=1.
- `alarm_set` 24'h000002, run:
  - `alarm` rises with the 00:00:02 tick and stays high through 00:00:05.
  - `alarm_clr` drops it.
  - A later `load` of 00:00:02 leaves `alarm`=0.
- `load` asserted on the exact prescaler terminal cycle → no `sec_tick`; the next tick occurs 4 cycles after the load edge.
